// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-requester arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc_4to2.sv
// Combinational 4-to-2 priority encoder; bit 3 has the highest priority.
module prio_enc_4to2
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        if (vec[3])      idx = 2'd3;
        else if (vec[2]) idx = 2'd2;
        else if (vec[1]) idx = 2'd1;
        any = |vec;
    end

endmodule

// File: rtl/req_arbiter_4.sv
// Fixed-priority arbiter with hold timer, one dead cycle between owners and
// a one-shot mask that lets others in after a timeout.
module req_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic [N_REQ-1:0] mask, mask_nx;
    logic             timeout_nx;

    logic [N_REQ-1:0] elig_raw, elig;
    logic [IDX_W-1:0] winner;
    logic             any;

    // Fall back to the raw requests so the mask can never starve a lone requester.
    always_comb begin
        elig_raw = req & ~mask;
        elig     = (elig_raw == '0) ? req : elig_raw;
    end

    prio_enc_4to2 u_enc (
        .vec (elig),
        .idx (winner),
        .any (any)
    );

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        hold_nx    = hold_cnt;
        mask_nx    = mask;
        timeout_nx = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                if (any) begin
                    state_nx = GRANT;
                    owner_nx = winner;
                    hold_nx  = '0;
                    mask_nx  = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_nx = RELEASE;
                end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    state_nx   = RELEASE;
                    timeout_nx = 1'b1;
                    mask_nx    = idx_to_onehot(owner);
                end else begin
                    hold_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            mask      <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            hold_cnt  <= hold_nx;
            mask      <= mask_nx;
            timeout   <= timeout_nx;
            gnt_valid <= (state_nx == GRANT);
            gnt       <= (state_nx == GRANT) ? idx_to_onehot(owner_nx) : '0;
            gnt_idx   <= (state_nx == GRANT) ? owner_nx : '0;
        end
    end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Self-checking bench for req_arbiter_4: directed scenarios plus a reference-model scoreboard.
module tb_req_arbiter_4;

    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];

    // Reference model state
    int         m_state = 0;   // 0 idle, 1 granted, 2 dead cycle
    logic [1:0] m_owner = '0;
    int         m_cnt   = 0;
    logic [3:0] m_mask  = '0;

    int         run_len  = 0;
    logic [3:0] prev_gnt = '0;

    req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Predict outputs after the coming edge and queue them.
    task automatic model_edge(input logic [3:0] r, input logic rv);
        exp_t       e;
        logic [3:0] el;
        int         w;
        e = '0;
        if (rv) begin
            m_state = 0; m_owner = '0; m_cnt = 0; m_mask = '0;
        end else begin
            el = r & ~m_mask;
            if (el == 4'b0000) el = r;
            w = -1;
            for (int i = 3; i >= 0; i--)
                if (el[i] && w < 0) w = i;
            if (m_state == 1) begin
                if (!r[m_owner]) m_state = 2;
                else if (m_cnt == MAX_HOLD - 1) begin
                    m_state = 2;
                    e.timeout = 1'b1;
                    m_mask = 4'b0001 << m_owner;
                end else m_cnt++;
            end else if (w >= 0) begin
                m_state = 1; m_owner = w[1:0]; m_cnt = 0; m_mask = '0;
            end else begin
                m_state = 0;
            end
        end
        if (m_state == 1) begin
            e.gnt = 4'b0001 << m_owner;
            e.idx = m_owner;
            e.valid = 1'b1;
        end
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] r);
        req = r;
        model_edge(r, rst);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and invariant monitor, sampling mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
                failures++;
                $display("FAIL sb_outputs t=%0t got gnt=%b idx=%0d valid=%b to=%b expected gnt=%b idx=%0d valid=%b to=%b",
                         $time, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.timeout);
            end
        end
        checks++;
        if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
            failures++;
            $display("FAIL onehot_valid t=%0t gnt=%b valid=%b", $time, gnt, gnt_valid);
        end
        checks++;
        if (gnt_valid ? (gnt[gnt_idx] !== 1'b1) : (gnt_idx !== 2'b00)) begin
            failures++;
            $display("FAIL idx_consistency t=%0t gnt=%b idx=%0d", $time, gnt, gnt_idx);
        end
        if (gnt_valid && gnt == prev_gnt) run_len++;
        else run_len = gnt_valid ? 1 : 0;
        prev_gnt = gnt;
        checks++;
        if (run_len > MAX_HOLD) begin
            failures++;
            $display("FAIL hold_limit t=%0t run=%0d max=%0d", $time, run_len, MAX_HOLD);
        end
    end

    task automatic to_idle();
        cycle(4'b0000);
        cycle(4'b0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(4'b1111);
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got gnt=%b valid=%b to=%b expected 0000/0/0", gnt, gnt_valid, timeout);
            end
        end
        rst = 1'b0;
        cycle(4'b1111);
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin
            failures++;
            $display("FAIL reset_first_grant got gnt=%b idx=%b expected 1000/11", gnt, gnt_idx);
        end
        to_idle();
    endtask

    task automatic test_priority();
        cycle(4'b0010);
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'b01) begin
            failures++;
            $display("FAIL prio_grant got gnt=%b idx=%b expected 0010/01", gnt, gnt_idx);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010);
            checks++;
            if (gnt !== 4'b0010) begin
                failures++;
                $display("FAIL no_preempt got gnt=%b expected 0010", gnt);
            end
        end
        cycle(4'b1000);
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL dead_cycle got gnt=%b valid=%b expected 0000/0", gnt, gnt_valid);
        end
        cycle(4'b1000);
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin
            failures++;
            $display("FAIL next_owner got gnt=%b idx=%b expected 1000/11", gnt, gnt_idx);
        end
        to_idle();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < MAX_HOLD; i++) begin
            cycle(4'b0101);
            checks++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_hold cycle=%0d got gnt=%b to=%b expected 0100/0", i, gnt, timeout);
            end
        end
        cycle(4'b0101);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulse got gnt=%b to=%b expected 0000/1", gnt, timeout);
        end
        cycle(4'b0101);
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'b00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_mask got gnt=%b idx=%b to=%b expected 0001/00/0", gnt, gnt_idx, timeout);
        end
        to_idle();
    endtask

    task automatic test_lone_timeout();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MAX_HOLD; i++) begin
                cycle(4'b0001);
                checks++;
                if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL lone_hold period=%0d cycle=%0d got gnt=%b to=%b expected 0001/0", p, i, gnt, timeout);
                end
            end
            cycle(4'b0001);
            checks++;
            if (gnt !== 4'b0000 || timeout !== 1'b1) begin
                failures++;
                $display("FAIL lone_pulse period=%0d got gnt=%b to=%b expected 0000/1", p, gnt, timeout);
            end
        end
        to_idle();
    endtask

    task automatic test_drop_on_final();
        for (int i = 0; i < MAX_HOLD; i++) cycle(4'b0011);
        cycle(4'b0001);
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL drop_final got gnt=%b to=%b expected 0000/0", gnt, timeout);
        end
        cycle(4'b0011);
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'b01) begin
            failures++;
            $display("FAIL drop_unmasked got gnt=%b idx=%b expected 0010/01", gnt, gnt_idx);
        end
        to_idle();
    endtask

    task automatic test_random();
        logic [3:0] r;
        int         len;
        for (int v = 0; v < 30; v++) begin
            r   = 4'($urandom_range(0, 15));
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) cycle(r);
        end
        to_idle();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_priority();
        test_timeout();
        test_lone_timeout();
        test_drop_on_final();
        test_random();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
